linebuffer_writer: RTL and testbench



---
 rtl/linebuffer_writer.sv | 173 +++++++++++++++++
 tb/tb_linebuffer_writer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/linebuffer_writer.sv
// Draw-side line buffer write initiator: coalesces single-pixel writes into 128-bit
// word writes with byte enables, plus a full-line clear sequencer.
module linebuffer_writer #(
   parameter logic [7:0] CLEAR_COLOUR   = 8'h00,
   parameter logic [7:0] TRANSPARENT    = 8'h00,
   parameter bit         TRANSPARENT_EN = 1'b1
) (
   input  logic         clk_draw,
   input  logic         rst_draw_n,
   input  logic         clear_start,
   output logic         busy,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [10:0]  in_x,
   input  logic [7:0]   in_colour,
   input  logic         in_last,
   output logic [6:0]   addr_draw,
   output logic [15:0]  we_draw,
   output logic [127:0] colour_draw
);

   typedef enum logic [0:0] {StRun, StClear} state_e;

   state_e         state_q, state_d;
   logic [6:0]     cnt_q, cnt_d;
   logic [6:0]     hold_addr_q, hold_addr_d;
   logic [127:0]   hold_data_q, hold_data_d;
   logic [15:0]    hold_mask_q, hold_mask_d;
   logic           hold_valid_q, hold_valid_d;
   logic           pend_q, pend_d;
   logic [6:0]     addr_q, addr_d;
   logic [15:0]    we_q, we_d;
   logic [127:0]   colour_q, colour_d;
   logic           busy_q, busy_d;
   logic           ready_q, ready_d;

   logic           opaque, same;
   logic [127:0]   merge_data;
   logic [15:0]    merge_mask;
   logic           emit;
   logic [6:0]     emit_addr;
   logic [127:0]   emit_data;
   logic [15:0]    emit_mask;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      hold_addr_d  = hold_addr_q;
      hold_data_d  = hold_data_q;
      hold_mask_d  = hold_mask_q;
      hold_valid_d = hold_valid_q;
      pend_d       = pend_q;
      addr_d       = addr_q;
      we_d         = '0;
      colour_d     = colour_q;
      busy_d       = busy_q;
      ready_d      = ready_q;
      emit         = 1'b0;
      emit_addr    = hold_addr_q;
      emit_data    = hold_data_q;
      emit_mask    = hold_mask_q;

      opaque = !(TRANSPARENT_EN && (in_colour == TRANSPARENT));
      same   = hold_valid_q && (in_x[10:4] == hold_addr_q);
      // A pixel starting a new word begins from a zeroed word, not stale hold data.
      merge_data = same ? hold_data_q : '0;
      merge_mask = same ? hold_mask_q : '0;
      if (opaque) begin
         merge_data[{in_x[3:0], 3'b000} +: 8] = in_colour;
         merge_mask[in_x[3:0]]                = 1'b1;
      end

      unique case (state_q)
         StRun: begin
            if (clear_start) begin
               state_d      = StClear;
               cnt_d        = '0;
               hold_valid_d = 1'b0;
               hold_mask_d  = '0;
               pend_d       = 1'b0;
               busy_d       = 1'b1;
               ready_d      = 1'b0;
               addr_d       = '0;
               we_d         = '1;
               colour_d     = {16{CLEAR_COLOUR}};
            end else if (pend_q) begin
               // Second half of an in_last double emit: flush the reloaded word.
               emit         = 1'b1;
               hold_valid_d = 1'b0;
               hold_mask_d  = '0;
               pend_d       = 1'b0;
               ready_d      = 1'b1;
            end else if (in_valid) begin
               hold_addr_d  = in_x[10:4];
               hold_data_d  = merge_data;
               hold_mask_d  = merge_mask;
               hold_valid_d = 1'b1;
               if (hold_valid_q && !same) begin
                  emit = 1'b1;
                  if (in_last) begin
                     pend_d  = 1'b1;
                     ready_d = 1'b0;
                  end
               end else if (in_last) begin
                  emit         = 1'b1;
                  emit_addr    = in_x[10:4];
                  emit_data    = merge_data;
                  emit_mask    = merge_mask;
                  hold_valid_d = 1'b0;
                  hold_mask_d  = '0;
               end
            end
         end
         StClear: begin
            if (cnt_q == 7'd127) begin
               state_d = StRun;
               busy_d  = 1'b0;
               ready_d = 1'b1;
            end else begin
               cnt_d    = cnt_q + 7'd1;
               addr_d   = cnt_q + 7'd1;
               we_d     = '1;
               colour_d = {16{CLEAR_COLOUR}};
            end
         end
         default: state_d = StRun;
      endcase

      // Words with no enabled bytes are dropped without touching the outputs.
      if (emit && (|emit_mask)) begin
         addr_d   = emit_addr;
         we_d     = emit_mask;
         colour_d = emit_data;
      end
   end

   always_ff @(posedge clk_draw or negedge rst_draw_n) begin
      if (!rst_draw_n) begin
         state_q      <= StRun;
         cnt_q        <= '0;
         hold_addr_q  <= '0;
         hold_data_q  <= '0;
         hold_mask_q  <= '0;
         hold_valid_q <= 1'b0;
         pend_q       <= 1'b0;
         addr_q       <= '0;
         we_q         <= '0;
         colour_q     <= '0;
         busy_q       <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hold_addr_q  <= hold_addr_d;
         hold_data_q  <= hold_data_d;
         hold_mask_q  <= hold_mask_d;
         hold_valid_q <= hold_valid_d;
         pend_q       <= pend_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         colour_q     <= colour_d;
         busy_q       <= busy_d;
         ready_q      <= ready_d;
      end
   end

   assign in_ready    = ready_q && !clear_start;
   assign busy        = busy_q;
   assign addr_draw   = addr_q;
   assign we_draw     = we_q;
   assign colour_draw = colour_q;

endmodule

// File: tb/tb_linebuffer_writer.sv
// Directed bench for linebuffer_writer: coalescing, in_last flushes, transparency,
// clear sequencing and asynchronous reset during a clear.
module tb_linebuffer_writer;

   logic         clk_draw = 1'b0;
   logic         rst_draw_n;
   logic         clear_start;
   logic         busy;
   logic         in_valid;
   logic         in_ready;
   logic [10:0]  in_x;
   logic [7:0]   in_colour;
   logic         in_last;
   logic [6:0]   addr_draw;
   logic [15:0]  we_draw;
   logic [127:0] colour_draw;

   int checks = 0;
   int passed = 0;

   linebuffer_writer dut (
      .clk_draw    (clk_draw),
      .rst_draw_n  (rst_draw_n),
      .clear_start (clear_start),
      .busy        (busy),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_x        (in_x),
      .in_colour   (in_colour),
      .in_last     (in_last),
      .addr_draw   (addr_draw),
      .we_draw     (we_draw),
      .colour_draw (colour_draw)
   );

   always #5 clk_draw = ~clk_draw;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk_draw);
      #1;
   endtask

   task automatic send(input int x, input int c, input bit last);
      in_valid  = 1'b1;
      in_x      = 11'(x);
      in_colour = 8'(c);
      in_last   = last;
      step();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      step();
   endtask

   logic [127:0] exp_col;

   initial begin
      rst_draw_n  = 1'b0;
      clear_start = 1'b0;
      in_valid    = 1'b0;
      in_x        = '0;
      in_colour   = '0;
      in_last     = 1'b0;
      #12;
      rst_draw_n = 1'b1;
      check("reset_we", 128'(we_draw), 128'h0);
      check("reset_addr", 128'(addr_draw), 128'h0);
      check("reset_colour", colour_draw, 128'h0);
      check("reset_ready", 128'(in_ready), 128'h1);
      check("reset_busy", 128'(busy), 128'h0);
      for (int i = 0; i < 3; i++) begin
         idle();
         check("idle_we", 128'(we_draw), 128'h0);
         check("idle_ready", 128'(in_ready), 128'h1);
         check("idle_busy", 128'(busy), 128'h0);
      end

      // Full word x=16..31, colours 1..16, last on x=31.
      exp_col = '0;
      for (int l = 0; l < 16; l++) begin
         exp_col[8*l +: 8] = 8'(l + 1);
         send(16 + l, l + 1, l == 15);
         if (l != 15) check("full_nowrite", 128'(we_draw), 128'h0);
      end
      check("full_we", 128'(we_draw), 128'hFFFF);
      check("full_addr", 128'(addr_draw), 128'h1);
      check("full_colour", colour_draw, exp_col);
      idle();
      check("full_single", 128'(we_draw), 128'h0);

      // Overwrite on lane 5, then address change with in_last: double emit.
      send(5, 8'h22, 1'b0);
      check("ow_nowrite0", 128'(we_draw), 128'h0);
      send(5, 8'h33, 1'b0);
      check("ow_nowrite1", 128'(we_draw), 128'h0);
      send(40, 8'h44, 1'b1);
      check("dbl0_we", 128'(we_draw), 128'h0020);
      check("dbl0_addr", 128'(addr_draw), 128'h0);
      check("dbl0_colour", colour_draw, 128'h33 << 40);
      check("dbl0_ready", 128'(in_ready), 128'h0);
      idle();
      check("dbl1_we", 128'(we_draw), 128'h0100);
      check("dbl1_addr", 128'(addr_draw), 128'h2);
      check("dbl1_colour", colour_draw, 128'h44 << 64);
      check("dbl1_ready", 128'(in_ready), 128'h1);
      idle();
      check("dbl_end_we", 128'(we_draw), 128'h0);

      // All-transparent word is dropped; outputs other than we hold.
      for (int l = 0; l < 16; l++) send(l, 0, l == 15);
      check("transp_we", 128'(we_draw), 128'h0);
      check("transp_addr_hold", 128'(addr_draw), 128'h2);
      check("transp_colour_hold", colour_draw, 128'h44 << 64);
      idle();
      check("transp_we_after", 128'(we_draw), 128'h0);
      for (int l = 0; l < 16; l++) send(l, (l == 3) ? 8'h07 : 8'h00, l == 15);
      check("one_opaque_we", 128'(we_draw), 128'h0008);
      check("one_opaque_addr", 128'(addr_draw), 128'h0);
      check("one_opaque_colour", colour_draw, 128'h07 << 24);
      idle();

      // Held pixel at x=100 then clear: hold discarded, 128 clear writes.
      send(100, 8'h55, 1'b0);
      in_valid    = 1'b0;
      clear_start = 1'b1;
      #1;
      check("clr_ready_comb", 128'(in_ready), 128'h0);
      step();
      clear_start = 1'b0;
      check("clr0_busy", 128'(busy), 128'h1);
      check("clr0_addr", 128'(addr_draw), 128'h0);
      check("clr0_we", 128'(we_draw), 128'hFFFF);
      check("clr0_colour", colour_draw, 128'h0);
      for (int i = 1; i < 128; i++) begin
         clear_start = (i == 60);
         step();
         check("clr_addr", 128'(addr_draw), 128'(i));
         check("clr_we", 128'(we_draw), 128'hFFFF);
         check("clr_busy", 128'(busy), 128'h1);
         check("clr_ready", 128'(in_ready), 128'h0);
      end
      clear_start = 1'b0;
      step();
      check("clr_done_busy", 128'(busy), 128'h0);
      check("clr_done_we", 128'(we_draw), 128'h0);
      check("clr_done_ready", 128'(in_ready), 128'h1);
      send(97, 8'h66, 1'b1);
      check("post_clr_we", 128'(we_draw), 128'h0002);
      check("post_clr_addr", 128'(addr_draw), 128'h6);
      check("post_clr_colour", colour_draw, 128'h66 << 8);
      idle();

      // Asynchronous reset in the middle of a clear.
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      for (int i = 1; i <= 50; i++) step();
      check("mid_clr_addr", 128'(addr_draw), 128'd50);
      rst_draw_n = 1'b0;
      #1;
      check("arst_we", 128'(we_draw), 128'h0);
      check("arst_addr", 128'(addr_draw), 128'h0);
      check("arst_colour", colour_draw, 128'h0);
      check("arst_busy", 128'(busy), 128'h0);
      check("arst_ready", 128'(in_ready), 128'h1);
      #3;
      rst_draw_n = 1'b1;
      step();
      check("rel_busy", 128'(busy), 128'h0);
      check("rel_we", 128'(we_draw), 128'h0);
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      check("reclr_addr", 128'(addr_draw), 128'h0);
      check("reclr_we", 128'(we_draw), 128'hFFFF);
      check("reclr_busy", 128'(busy), 128'h1);
      for (int i = 1; i < 128; i++) step();
      check("reclr_last_addr", 128'(addr_draw), 128'd127);
      step();
      check("reclr_done_busy", 128'(busy), 128'h0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
